// File: rtl/cardinal_pkg.sv
// Shared constants for the Cardinal NIC: register map,
// status bit positions and packet field positions.
package cardinal_pkg;

  typedef enum logic [1:0] {
    IN_BUF   = 2'b00,
    IN_STAT  = 2'b01,
    OUT_BUF  = 2'b10,
    OUT_STAT = 2'b11
  } reg_addr_e;

  localparam int ST_IN_NE    = 0;
  localparam int ST_IN_FULL  = 1;
  localparam int ST_OUT_FULL = 0;
  localparam int ST_OVF      = 1;
  localparam int ST_CNT_W    = 5;

  localparam int PKT_VC_BIT  = 0;
  localparam int PKT_DIR_BIT = 1;
  localparam int PKT_HOP_POS = 8;
  localparam int PKT_HOP_W   = 8;
  localparam int PKT_SRC_POS = 16;
  localparam int PKT_SRC_W   = 16;

endpackage

// File: rtl/cardinal_nic_fifo_if.sv
// Processor register bus and ring send/ready channel
// of the Cardinal NIC, bundled for the NIC port list.
interface cardinal_nic_fifo_if #(
  parameter int DATA_W = 64
) ();
  logic [1:0]        addr;
  logic              nicEn;
  logic              nicWrEn;
  logic [0:DATA_W-1] d_in;
  logic [0:DATA_W-1] d_out;
  logic              net_si;
  logic              net_ri;
  logic [0:DATA_W-1] net_di;
  logic              net_so;
  logic              net_ro;
  logic [0:DATA_W-1] net_do;
  logic              net_polarity;

  modport slave (
    input  addr, nicEn, nicWrEn, d_in,
    input  net_si, net_di, net_ro,
    input  net_polarity,
    output d_out, net_ri, net_so, net_do
  );

  modport master (
    output addr, nicEn, nicWrEn, d_in,
    output net_si, net_di, net_ro,
    output net_polarity,
    input  d_out, net_ri, net_so, net_do
  );
endinterface

// File: rtl/cardinal_sync_fifo.sv
// Single-clock FIFO with combinational head; illegal
// push-when-full and pop-when-empty are ignored.
module cardinal_sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [0:DATA_W-1] wdata,
  output logic [0:DATA_W-1] rdata,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [0:DATA_W-1] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_en, rd_en;

  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign rdata = mem_q[rptr_q];
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + CW'(wr_en) - CW'(rd_en);
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/cardinal_nic_fifo.sv
// Cardinal NIC: register decode, read-data register,
// overflow flag and polarity-gated ring injection.
module cardinal_nic_fifo
  import cardinal_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 4,
  parameter int VC_BIT    = PKT_VC_BIT,
  parameter int POL_CHECK = 1,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input logic               clk,
  input logic               reset,
  cardinal_nic_fifo_if.slave bus
);

  logic [0:DATA_W-1] in_head, out_head;
  logic [0:DATA_W-1] in_stat, out_stat;
  logic [0:DATA_W-1] d_out_q, d_out_d;
  logic [CW-1:0]     in_cnt, out_cnt;
  logic in_full, in_empty, out_full, out_empty;
  logic in_push, in_pop, out_push, send;
  logic rd_acc, wr_acc, pol_ok, ovf_set;
  logic sel_ib, sel_is, sel_ob, sel_os;
  logic ovf_q, ovf_d;

  assign rd_acc = bus.nicEn & ~bus.nicWrEn;
  assign wr_acc = bus.nicEn & bus.nicWrEn;
  assign sel_ib = bus.addr == IN_BUF;
  assign sel_is = bus.addr == IN_STAT;
  assign sel_ob = bus.addr == OUT_BUF;
  assign sel_os = bus.addr == OUT_STAT;

  assign bus.net_ri = reset & ~in_full;
  assign in_push    = bus.net_si & bus.net_ri;
  assign in_pop     = rd_acc & sel_ib & ~in_empty;
  assign out_push   = wr_acc & sel_ob;
  assign ovf_set    = out_push & out_full;

  assign pol_ok = (POL_CHECK == 0) |
                  (bus.net_polarity == out_head[VC_BIT]);
  assign send   = reset & ~out_empty & bus.net_ro & pol_ok;
  assign bus.net_so = send;
  assign bus.net_do = (reset & ~out_empty) ? out_head : '0;
  assign bus.d_out  = d_out_q;

  cardinal_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in (
    .clk(clk), .reset(reset),
    .push(in_push), .pop(in_pop),
    .wdata(bus.net_di), .rdata(in_head),
    .full(in_full), .empty(in_empty), .count(in_cnt)
  );

  cardinal_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out (
    .clk(clk), .reset(reset),
    .push(out_push), .pop(send),
    .wdata(bus.d_in), .rdata(out_head),
    .full(out_full), .empty(out_empty), .count(out_cnt)
  );

  always_comb begin
    in_stat = '0;
    in_stat[ST_IN_NE]   = ~in_empty;
    in_stat[ST_IN_FULL] = in_full;
    in_stat[DATA_W-ST_CNT_W +: ST_CNT_W] =
      ST_CNT_W'(in_cnt);
    out_stat = '0;
    out_stat[ST_OUT_FULL] = out_full;
    out_stat[ST_OVF]      = ovf_q;
    out_stat[DATA_W-ST_CNT_W +: ST_CNT_W] =
      ST_CNT_W'(out_cnt);
  end

  always_comb begin
    d_out_d = d_out_q;
    if (rd_acc) begin
      unique case (1'b1)
        sel_ib:  d_out_d = in_empty ? '0 : in_head;
        sel_is:  d_out_d = in_stat;
        sel_os:  d_out_d = out_stat;
        default: d_out_d = '0;
      endcase
    end
  end

  // A fresh overflow wins over the clear-on-read.
  assign ovf_d = ovf_set | (ovf_q & ~(rd_acc & sel_os));

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_out_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      d_out_q <= d_out_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// Directed bench for cardinal_nic_fifo (DEPTH=4,
// POL_CHECK=1, VC tag in bit 0 = MSB).
module tb_cardinal_nic_fifo;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cardinal_nic_fifo_if #(.DATA_W(64)) bus ();

  cardinal_nic_fifo #(
    .DATA_W(64), .DEPTH(4), .VC_BIT(0), .POL_CHECK(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a,
                    output logic [63:0] v);
    bus.addr    = a;
    bus.nicEn   = 1'b1;
    bus.nicWrEn = 1'b0;
    tick();
    bus.nicEn = 1'b0;
    v = bus.d_out;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [63:0] d);
    bus.addr    = a;
    bus.nicEn   = 1'b1;
    bus.nicWrEn = 1'b1;
    bus.d_in    = d;
    tick();
    bus.nicEn   = 1'b0;
    bus.nicWrEn = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] v;
    reset = 1'b0;
    repeat (3) tick();
    n_chk += 4;
    if (bus.net_ri !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ri got %b want 0", bus.net_ri);
    end
    if (bus.net_so !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_so got %b want 0", bus.net_so);
    end
    if (bus.net_do !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_do got %h want 0", bus.net_do);
    end
    if (bus.d_out !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_dout got %h want 0", bus.d_out);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (bus.net_ri !== 1'b1) begin
      n_fail++;
      $display("FAIL rel_ri got %b want 1", bus.net_ri);
    end
    rd(2'b01, v);
    n_chk++;
    if (v !== 64'h0) begin
      n_fail++;
      $display("FAIL rel_instat got %h want 0", v);
    end
    rd(2'b11, v);
    n_chk++;
    if (v !== 64'h0) begin
      n_fail++;
      $display("FAIL rel_outstat got %h want 0", v);
    end
  endtask

  task automatic test_out_overflow();
    logic [63:0] v;
    logic [63:0] exp_q [4];
    exp_q = '{64'h11, 64'h22, 64'h33, 64'h44};
    bus.net_ro = 1'b0;
    bus.net_polarity = 1'b0;
    for (int i = 0; i < 5; i++)
      wr(2'b10, 64'h11 * (i + 1));
    n_chk += 2;
    if (bus.net_do !== 64'h11) begin
      n_fail++;
      $display("FAIL ovf_head got %h want 11", bus.net_do);
    end
    if (bus.net_so !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_so got %b want 0", bus.net_so);
    end
    rd(2'b11, v);
    n_chk++;
    if (v !== 64'hC000_0000_0000_0004) begin
      n_fail++;
      $display("FAIL ovf_stat1 got %h want c000000000000004",
               v);
    end
    rd(2'b11, v);
    n_chk++;
    if (v !== 64'h8000_0000_0000_0004) begin
      n_fail++;
      $display("FAIL ovf_stat2 got %h want 8000000000000004",
               v);
    end
    bus.net_ro = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk += 2;
      if (bus.net_so !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_so[%0d] got %b want 1",
                 i, bus.net_so);
      end
      if (bus.net_do !== exp_q[i]) begin
        n_fail++;
        $display("FAIL drain_do[%0d] got %h want %h",
                 i, bus.net_do, exp_q[i]);
      end
      tick();
    end
    #1;
    n_chk++;
    if (bus.net_so !== 1'b0 || bus.net_do !== 64'h0) begin
      n_fail++;
      $display("FAIL drain_end got so=%b do=%h want 0/0",
               bus.net_so, bus.net_do);
    end
    bus.net_ro = 1'b0;
  endtask

  task automatic test_polarity();
    logic        so_exp [5];
    logic [63:0] do_exp [5];
    so_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_exp = '{64'h8000_0000_0000_00A1,
               64'h8000_0000_0000_00A1,
               64'h8000_0000_0000_00A2,
               64'h8000_0000_0000_00A2,
               64'h0};
    bus.net_ro = 1'b0;
    bus.net_polarity = 1'b0;
    wr(2'b10, 64'h8000_0000_0000_00A1);
    wr(2'b10, 64'h8000_0000_0000_00A2);
    bus.net_ro = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.net_polarity = c[0];
      #1;
      n_chk += 2;
      if (bus.net_so !== so_exp[c]) begin
        n_fail++;
        $display("FAIL pol_so[%0d] got %b want %b",
                 c, bus.net_so, so_exp[c]);
      end
      if (bus.net_do !== do_exp[c]) begin
        n_fail++;
        $display("FAIL pol_do[%0d] got %h want %h",
                 c, bus.net_do, do_exp[c]);
      end
      tick();
    end
    bus.net_ro = 1'b0;
    bus.net_polarity = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [63:0] v;
    logic        ri_exp;
    for (int k = 0; k < 6; k++) begin
      bus.net_si = 1'b1;
      bus.net_di = 64'h100 + 64'(k);
      #1;
      ri_exp = (k < 4);
      n_chk++;
      if (bus.net_ri !== ri_exp) begin
        n_fail++;
        $display("FAIL bp_ri[%0d] got %b want %b",
                 k, bus.net_ri, ri_exp);
      end
      tick();
    end
    bus.net_si = 1'b0;
    rd(2'b01, v);
    n_chk++;
    if (v !== 64'hC000_0000_0000_0004) begin
      n_fail++;
      $display("FAIL bp_stat got %h want c000000000000004",
               v);
    end
    rd(2'b00, v);
    n_chk += 2;
    if (v !== 64'h100) begin
      n_fail++;
      $display("FAIL bp_first got %h want 100", v);
    end
    if (bus.net_ri !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ri_after got %b want 1", bus.net_ri);
    end
    for (int k = 1; k < 4; k++) begin
      rd(2'b00, v);
      n_chk++;
      if (v !== 64'h100 + 64'(k)) begin
        n_fail++;
        $display("FAIL bp_rd[%0d] got %h want %h",
                 k, v, 64'h100 + 64'(k));
      end
    end
    rd(2'b01, v);
    n_chk++;
    if (v !== 64'h0) begin
      n_fail++;
      $display("FAIL bp_stat_end got %h want 0", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v, exp_v;
    for (int k = 0; k <= 20; k++) begin
      bus.net_si  = (k < 20);
      bus.net_di  = 64'h200 + 64'(k);
      bus.addr    = 2'b00;
      bus.nicEn   = 1'b1;
      bus.nicWrEn = 1'b0;
      #1;
      n_chk++;
      if (bus.net_ri !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ri[%0d] got %b want 1",
                 k, bus.net_ri);
      end
      tick();
      exp_v = (k == 0) ? 64'h0 : 64'h200 + 64'(k - 1);
      n_chk++;
      if (bus.d_out !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_rd[%0d] got %h want %h",
                 k, bus.d_out, exp_v);
      end
    end
    bus.net_si = 1'b0;
    bus.nicEn  = 1'b0;
    rd(2'b00, v);
    n_chk++;
    if (v !== 64'h0) begin
      n_fail++;
      $display("FAIL empty_rd got %h want 0", v);
    end
    rd(2'b01, v);
    n_chk++;
    if (v !== 64'h0) begin
      n_fail++;
      $display("FAIL empty_stat got %h want 0", v);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] v;
    bus.net_ro = 1'b0;
    bus.net_polarity = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.net_si  = 1'b1;
      bus.net_di  = 64'h300 + 64'(k);
      bus.addr    = 2'b10;
      bus.nicEn   = 1'b1;
      bus.nicWrEn = 1'b1;
      bus.d_in    = 64'h400 + 64'(k);
      tick();
    end
    bus.net_si  = 1'b0;
    bus.nicEn   = 1'b0;
    bus.nicWrEn = 1'b0;
    rd(2'b11, v);
    n_chk++;
    if (v !== 64'h3) begin
      n_fail++;
      $display("FAIL mid_pre got %h want 3", v);
    end
    reset = 1'b0;
    bus.net_ro = 1'b1;
    #1;
    n_chk += 3;
    if (bus.net_so !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_so got %b want 0", bus.net_so);
    end
    if (bus.net_ri !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_ri got %b want 0", bus.net_ri);
    end
    if (bus.net_do !== 64'h0) begin
      n_fail++;
      $display("FAIL mid_do got %h want 0", bus.net_do);
    end
    tick();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.net_polarity = c[0];
      #1;
      n_chk++;
      if (bus.net_so !== 1'b0 || bus.net_do !== 64'h0) begin
        n_fail++;
        $display("FAIL stale[%0d] got so=%b do=%h want 0/0",
                 c, bus.net_so, bus.net_do);
      end
      tick();
    end
    bus.net_ro = 1'b0;
    bus.net_polarity = 1'b0;
    rd(2'b01, v);
    n_chk++;
    if (v !== 64'h0) begin
      n_fail++;
      $display("FAIL mid_instat got %h want 0", v);
    end
    rd(2'b11, v);
    n_chk++;
    if (v !== 64'h0) begin
      n_fail++;
      $display("FAIL mid_outstat got %h want 0", v);
    end
  endtask

  initial begin
    reset            = 1'b0;
    bus.addr         = 2'b00;
    bus.nicEn        = 1'b0;
    bus.nicWrEn      = 1'b0;
    bus.d_in         = '0;
    bus.net_si       = 1'b0;
    bus.net_di       = '0;
    bus.net_ro       = 1'b0;
    bus.net_polarity = 1'b0;
    test_reset();
    test_out_overflow();
    test_polarity();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
